// File: rtl/pitch_colour_ctrl.sv
// Turns pitch measurements into the registered 12-bit quadrant colour word for the VGA stage.
// Optional build macro: BLINK_EN enables the activity blink on the bottom-right quadrant.
module pitch_colour_ctrl #(
    parameter int CENTS_W        = 8,
    parameter int TOL_CENTS      = 10,
    parameter int STABLE_COUNT   = 8,
    parameter int TIMEOUT_CYCLES = 25_000_000,
    parameter int BLINK_HALF     = 6_250_000
) (
    input  logic               clk_25MHz,
    input  logic               rst,
    input  logic               pitch_valid,
    output logic               pitch_ready,
    input  logic [3:0]         pitch_note,
    input  logic [CENTS_W-1:0] pitch_cents,
    output logic [11:0]        colour_ctrl,
    output logic               locked,
    output logic [1:0]         dbg_state
);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SC_W = $clog2(STABLE_COUNT + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, UPDATE = 2'd1, TRACK = 2'd2} state_t;
    state_t state;

    logic [3:0]         sample_note;
    logic [CENTS_W-1:0] sample_cents;
    logic [SC_W-1:0]    stable_cnt, stable_next;
    logic [TO_W-1:0]    timeout_cnt;
    logic [2:0]         tl_q, tr_q, bl_q;
    logic [2:0]         tl_next, tr_next, bl_next;
    logic               br_on, locked_next;
    logic               accept, timeout_hit, in_tune;
    logic [CENTS_W:0]   cents_ext, cents_abs;

    // Valid/ready: a sample transfers on a clk edge where pitch_valid && pitch_ready; ready drops
    // only for the single UPDATE cycle, and upstream must hold valid and data stable until ready.
    assign pitch_ready = (state != UPDATE);
    assign accept      = pitch_valid && pitch_ready;
    assign timeout_hit = (state == TRACK) && !accept
                         && (timeout_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign dbg_state   = state;
    assign colour_ctrl = {{3{br_on}}, bl_q, tr_q, tl_q};

    // One extra bit keeps |most-negative| representable.
    assign cents_ext = {sample_cents[CENTS_W-1], sample_cents};
    assign cents_abs = sample_cents[CENTS_W-1] ? (~cents_ext + (CENTS_W+1)'(1)) : cents_ext;
    assign in_tune   = (cents_abs <= (CENTS_W+1)'(TOL_CENTS));

    always_comb begin
        tl_next = 3'b010;
        if (!in_tune) tl_next = sample_cents[CENTS_W-1] ? 3'b001 : 3'b100;

        stable_next = '0;
        if (in_tune) begin
            stable_next = (stable_cnt == SC_W'(STABLE_COUNT)) ? stable_cnt
                                                              : stable_cnt + SC_W'(1);
        end
        locked_next = (stable_next == SC_W'(STABLE_COUNT));

        tr_next = 3'b000;
        if (locked_next)            tr_next = 3'b010;
        else if (stable_next != '0) tr_next = 3'b110;

        bl_next = 3'b111;
        if (sample_note < 4'd7)       bl_next = sample_note[2:0] + 3'd1;
        else if (sample_note < 4'd12) bl_next = 3'(sample_note - 4'd6);
    end

`ifdef BLINK_EN
    localparam int BL_W = $clog2(BLINK_HALF + 1);
    logic [BL_W-1:0] blink_cnt;
`else
    // BLINK_HALF is meaningful only when the blink is built in.
    if (BLINK_HALF < 1) begin : g_blink_half_unused
    end
`endif

    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            state        <= IDLE;
            sample_note  <= '0;
            sample_cents <= '0;
            stable_cnt   <= '0;
            timeout_cnt  <= '0;
            tl_q         <= '0;
            tr_q         <= '0;
            bl_q         <= '0;
            br_on        <= 1'b0;
            locked       <= 1'b0;
`ifdef BLINK_EN
            blink_cnt    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sample_note  <= pitch_note;
                        sample_cents <= pitch_cents;
                        timeout_cnt  <= '0;
                        br_on        <= 1'b1;
                        state        <= UPDATE;
`ifdef BLINK_EN
                        blink_cnt    <= '0;
`endif
                    end
                end
                UPDATE: begin
                    tl_q       <= tl_next;
                    tr_q       <= tr_next;
                    bl_q       <= bl_next;
                    stable_cnt <= stable_next;
                    locked     <= locked_next;
                    state      <= TRACK;
                end
                TRACK: begin
                    if (accept) begin
                        sample_note  <= pitch_note;
                        sample_cents <= pitch_cents;
                        timeout_cnt  <= '0;
                        state        <= UPDATE;
                    end else if (timeout_hit) begin
                        tl_q       <= '0;
                        tr_q       <= '0;
                        bl_q       <= '0;
                        br_on      <= 1'b0;
                        stable_cnt <= '0;
                        locked     <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        timeout_cnt <= timeout_cnt + TO_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef BLINK_EN
            // Free-running through UPDATE so accepts inside a session keep the phase.
            if (state != IDLE && !timeout_hit) begin
                if (blink_cnt == BL_W'(BLINK_HALF - 1)) begin
                    blink_cnt <= '0;
                    br_on     <= ~br_on;
                end else begin
                    blink_cnt <= blink_cnt + BL_W'(1);
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_pitch_colour_ctrl.sv
// Bench for pitch_colour_ctrl: session-level reference model checked every cycle, plus
// hand-computed literal expectations for the directed scenarios.
module tb_pitch_colour_ctrl;
    localparam int TIMEOUT  = 100;
    localparam int BLINK_H  = 10;
    localparam int STABLE   = 3;
    localparam int TOL      = 10;
    localparam int M_IDLE   = 0;
    localparam int M_PEND   = 1;
    localparam int M_SHOW   = 2;

    logic        clk_25MHz = 1'b0;
    logic        rst = 1'b1;
    logic        pitch_valid = 1'b0;
    logic        pitch_ready;
    logic [3:0]  pitch_note = '0;
    logic [7:0]  pitch_cents = '0;
    logic [11:0] colour_ctrl;
    logic        locked;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    logic chk_en = 1'b0;

    pitch_colour_ctrl #(
        .CENTS_W(8), .TOL_CENTS(TOL), .STABLE_COUNT(STABLE),
        .TIMEOUT_CYCLES(TIMEOUT), .BLINK_HALF(BLINK_H)
    ) dut (
        .clk_25MHz(clk_25MHz), .rst(rst), .pitch_valid(pitch_valid), .pitch_ready(pitch_ready),
        .pitch_note(pitch_note), .pitch_cents(pitch_cents), .colour_ctrl(colour_ctrl),
        .locked(locked), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #20 clk_25MHz = ~clk_25MHz;

    initial begin
        #(40 * 5000);
        $display("FAIL watchdog: simulation did not finish within 5000 cycles");
        $fatal(1);
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic lit(input string name, input logic [11:0] e);
`ifdef BLINK_EN
        chk(name, {23'd0, colour_ctrl[8:0]}, {23'd0, e[8:0]});
`else
        chk(name, {20'd0, colour_ctrl}, {20'd0, e});
`endif
    endtask

    // ---------------- reference model ----------------
    int         m_mode = M_IDLE;
    int         m_run, m_quiet, m_age;
    logic [2:0] m_tl, m_tr, m_bl;
    logic [3:0] p_note;
    logic [7:0] p_cents;

    task automatic model_apply();
        int c;
        c = int'($signed(p_cents));
        if (c > TOL)       m_tl = 3'b100;
        else if (c < -TOL) m_tl = 3'b001;
        else               m_tl = 3'b010;
        if (c >= -TOL && c <= TOL) m_run = (m_run + 1 > STABLE) ? STABLE : m_run + 1;
        else                       m_run = 0;
        m_tr = (m_run == STABLE) ? 3'b010 : (m_run > 0) ? 3'b110 : 3'b000;
        m_bl = (p_note < 12) ? 3'(int'(p_note) % 7 + 1) : 3'b111;
    endtask

    always @(posedge clk_25MHz) begin
        if (rst) begin
            m_mode = M_IDLE; m_run = 0; m_quiet = 0; m_age = 0;
            m_tl = 0; m_tr = 0; m_bl = 0;
        end else if (m_mode == M_PEND) begin
            model_apply();
            m_mode = M_SHOW;
            m_age++;
        end else if (pitch_valid) begin
            m_age   = (m_mode == M_IDLE) ? 0 : m_age + 1;
            p_note  = pitch_note;
            p_cents = pitch_cents;
            m_quiet = 0;
            m_mode  = M_PEND;
        end else if (m_mode == M_SHOW) begin
            if (m_quiet == TIMEOUT - 1) begin
                m_mode = M_IDLE; m_run = 0; m_tl = 0; m_tr = 0; m_bl = 0;
            end else begin
                m_quiet++;
                m_age++;
            end
        end
    end

    // ---------------- scoreboard: every cycle ----------------
    logic [2:0]  exp_br;
    logic [11:0] exp_colour;
    always @(negedge clk_25MHz) begin
        if (chk_en) begin
            if (m_mode == M_IDLE) exp_br = 3'b000;
`ifdef BLINK_EN
            else exp_br = ((m_age / BLINK_H) % 2 == 0) ? 3'b111 : 3'b000;
`else
            else exp_br = 3'b111;
`endif
            exp_colour = {exp_br, m_bl, m_tr, m_tl};
            chk("model_colour", {20'd0, colour_ctrl}, {20'd0, exp_colour});
            chk("model_locked", {31'd0, locked}, {31'd0, m_run == STABLE});
            chk("model_ready", {31'd0, pitch_ready}, {31'd0, m_mode != M_PEND});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk_25MHz);
    endtask

    task automatic send(input logic [3:0] n, input logic [7:0] c);
        logic took;
        took = 1'b0;
        pitch_valid = 1'b1;
        pitch_note  = n;
        pitch_cents = c;
        for (int k = 0; k < 4; k++) begin
            took = pitch_ready;
            @(posedge clk_25MHz);
            if (took) break;
            @(negedge clk_25MHz);
        end
        @(negedge clk_25MHz);
        pitch_valid = 1'b0;
        chk("send_accept", {31'd0, took}, 32'd1);
    endtask

    // ---------------- directed stimulus ----------------
    logic [7:0]  rdy_pat;
    logic [19:0] br_pat;
    int          n_acc;

    initial begin
        tick(3);
        chk_en = 1'b1;
        chk("reset_colour", {20'd0, colour_ctrl}, 32'h000);
        chk("reset_locked", {31'd0, locked}, 32'd0);
        chk("reset_ready", {31'd0, pitch_ready}, 32'd1);
        chk("reset_state", {30'd0, dbg_state}, 32'd0);
        rst = 1'b0;

        // reset in the middle of UPDATE discards the captured sample
        send(4'd3, 8'd0);
        chk("update_ready_low", {31'd0, pitch_ready}, 32'd0);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick();
        chk("post_rst_colour", {20'd0, colour_ctrl}, 32'h000);
        chk("post_rst_locked", {31'd0, locked}, 32'd0);
        chk("post_rst_ready", {31'd0, pitch_ready}, 32'd1);

        // tuning colour: sharp, flat, in tune, most-negative
        send(4'd0, 8'd25);
        lit("sharp_pre", 12'hE00);
        tick();
        lit("sharp", 12'hE44);
        send(4'd0, 8'hE7);
        tick();
        lit("flat", 12'hE41);
        send(4'd0, 8'd4);
        tick();
        lit("in_tune", 12'hE72);
        send(4'd0, 8'h80);
        tick();
        lit("cents_min", 12'hE41);

        // stable count and lock
        send(4'd0, 8'd0); tick();
        lit("stable1", 12'hE72);
        send(4'd0, 8'd0); tick();
        lit("stable2", 12'hE72);
        chk("stable2_locked", {31'd0, locked}, 32'd0);
        send(4'd0, 8'd0); tick();
        lit("stable3", 12'hE52);
        chk("stable3_locked", {31'd0, locked}, 32'd1);
        send(4'd0, 8'd11); tick();
        lit("unlock", 12'hE44);
        chk("unlock_locked", {31'd0, locked}, 32'd0);

        // valid held high: one accept every two cycles, invalid note
        n_acc = 0;
        rdy_pat = '0;
        pitch_valid = 1'b1; pitch_note = 4'd13; pitch_cents = 8'd0;
        for (int i = 0; i < 8; i++) begin
            rdy_pat = {rdy_pat[6:0], pitch_ready};
            if (pitch_ready) n_acc++;
            tick();
        end
        pitch_valid = 1'b0;
        chk("ready_pattern", {24'd0, rdy_pat}, 32'hAA);
        chk("accept_count", n_acc, 32'd4);
        lit("note13", 12'hFD2);
        chk("note13_locked", {31'd0, locked}, 32'd1);

        // timeout blanks after 100 idle cycles in TRACK
        tick(99);
        lit("pre_timeout", 12'hFD2);
        tick();
        chk("timeout_colour", {20'd0, colour_ctrl}, 32'h000);
        chk("timeout_locked", {31'd0, locked}, 32'd0);

        // accept on the timeout edge wins
        send(4'd5, 8'd0); tick();
        lit("note5", 12'hFB2);
        tick(99);
        send(4'd2, 8'hE2);
        lit("no_blank", 12'hFB2);
        chk("no_blank_br", {29'd0, colour_ctrl[11:9]}, 32'd7);
        tick();
        lit("after_race", 12'hEC1);

        // activity quadrant over one session
        rst = 1'b1; tick(); rst = 1'b0; tick();
        send(4'd1, 8'd0);
        br_pat = '0;
        for (int i = 0; i < 20; i++) begin
            br_pat = {br_pat[18:0], colour_ctrl[11:9] == 3'b111};
            tick();
        end
`ifdef BLINK_EN
        chk("blink_pattern", {12'd0, br_pat}, 32'hFFC00);
`else
        chk("steady_br", {12'd0, br_pat}, 32'hFFFFF);
`endif
        send(4'd1, 8'd0);
        tick(5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
